// File: rtl/alu_issuer_pkg.sv
// Shared definitions for the ALU command issuer: FSM states, ALU unit-select codes,
// default response timeout and optional statistics counter widths.
package alu_issuer_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 7;
  localparam int unsigned FUN_W           = 4;
  localparam int unsigned OP_CNT_W        = 16;
  localparam int unsigned TO_CNT_W        = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_e;

endpackage

// File: rtl/alu_cmd_issuer_timer.sv
// issue_timer: loadable down-counter used to bound the wait for an ALU response.
// Width is sized so that TIMEOUT itself fits; the counter stops at zero.
module issue_timer #(
  parameter int unsigned TIMEOUT = alu_issuer_pkg::DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load has priority, decrement never wraps below zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CNT_W'(TIMEOUT);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: accepts one ALU command at a time, issues it with a single-cycle
// enable, waits (bounded by TIMEOUT) for the ALU result and hands it downstream.
// Optional macro ALU_ISSUER_STATS_EN adds op_count and timeout_count outputs.
module alu_cmd_issuer
  import alu_issuer_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RES_WIDTH = 8,
  parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  input  logic [FUN_W-1:0]     cmd_fun,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [FUN_W-1:0]     alu_fun,
  output logic                 alu_en,
  input  logic [RES_WIDTH-1:0] alu_res,
  input  logic                 alu_res_valid,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RES_WIDTH-1:0] res_data,
  output logic                 res_err,
`ifdef ALU_ISSUER_STATS_EN
  output logic [OP_CNT_W-1:0]  op_count,
  output logic [TO_CNT_W-1:0]  timeout_count,
`endif
  output logic                 busy
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [FUN_W-1:0]     alu_fun_q, alu_fun_d;
  logic                 alu_en_q, alu_en_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 res_valid_q, res_valid_d;
  logic [RES_WIDTH-1:0] res_data_q, res_data_d;
  logic                 res_err_q, res_err_d;
  logic                 busy_q, busy_d;
  logic                 t_load_c, t_dec_c, t_zero_c;

  issue_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .load   (t_load_c),
    .dec    (t_dec_c),
    .zero_c (t_zero_c)
  );

  // Next state, operand/result capture; status outputs follow the next state so they are registered
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_fun_d  = alu_fun_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    t_load_c   = 1'b0;
    t_dec_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_a_d   = cmd_a;
          alu_b_d   = cmd_b;
          alu_fun_d = cmd_fun;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        t_load_c = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (alu_res_valid) begin
          res_data_d = alu_res;
          res_err_d  = 1'b0;
          state_d    = DONE;
        end else if (t_zero_c) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = DONE;
        end else begin
          t_dec_c = 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    alu_en_d    = (state_d == ISSUE);
    res_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      alu_en_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      alu_en_q    <= alu_en_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fun   = alu_fun_q;
  assign alu_en    = alu_en_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;

`ifdef ALU_ISSUER_STATS_EN
  logic [OP_CNT_W-1:0] op_count_q, op_count_d;
  logic [TO_CNT_W-1:0] timeout_count_q, timeout_count_d;

  // Completed handshakes (wrapping) and timeouts (saturating)
  always_comb begin
    op_count_d      = op_count_q;
    timeout_count_d = timeout_count_q;
    if ((state_q == DONE) && res_ready) begin
      op_count_d = op_count_q + OP_CNT_W'(1);
    end
    if ((state_q == WAIT) && !alu_res_valid && t_zero_c && (timeout_count_q != '1)) begin
      timeout_count_d = timeout_count_q + TO_CNT_W'(1);
    end
  end

  // Statistics registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_count_q      <= '0;
      timeout_count_q <= '0;
    end else begin
      op_count_q      <= op_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign op_count      = op_count_q;
  assign timeout_count = timeout_count_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed vector table, hand-written
// multi-cycle sequences and randomized commands checked against a latency/result model.
module tb_alu_cmd_issuer;
  import alu_issuer_pkg::*;

  localparam int T = 7;

  logic       CLK = 1'b0;
  logic       RST;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a, cmd_b, cmd_fun;
  logic [3:0] alu_a, alu_b, alu_fun;
  logic       alu_en;
  logic [7:0] alu_res;
  logic       alu_res_valid;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_err;
  logic       busy;
`ifdef ALU_ISSUER_STATS_EN
  logic [15:0] op_count;
  logic [7:0]  timeout_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ops  = 0;
  int exp_to   = 0;

  // ALU responder controls
  int         resp_delay = 0;
  bit         resp_ovr   = 1'b0;
  logic [7:0] resp_val   = 8'd0;
  int         en_cyc[$];

  typedef struct {
    logic [3:0] a, b, fun;
    int         delay;
    bit         ovr;
    logic [7:0] ovr_val;
    int         hold;
    logic [7:0] exp_res;
    bit         exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  alu_cmd_issuer #(
    .WIDTH     (4),
    .RES_WIDTH (8),
    .TIMEOUT   (T)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_fun       (cmd_fun),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_fun       (alu_fun),
    .alu_en        (alu_en),
    .alu_res       (alu_res),
    .alu_res_valid (alu_res_valid),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_err       (res_err),
`ifdef ALU_ISSUER_STATS_EN
    .op_count      (op_count),
    .timeout_count (timeout_count),
`endif
    .busy          (busy)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU used both as responder and as expected-result reference
  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [3:0] fun);
    logic [7:0] ea;
    logic [7:0] eb;
    ea = 8'(a);
    eb = 8'(b);
    case (unit_e'(fun[3:2]))
      UNIT_ARITH: case (fun[1:0])
        2'd0: return ea + eb;
        2'd1: return ea - eb;
        2'd2: return ea * eb;
        default: return ea;
      endcase
      UNIT_LOGIC: case (fun[1:0])
        2'd0: return ea & eb;
        2'd1: return ea | eb;
        2'd2: return ea ^ eb;
        default: return 8'(~a);
      endcase
      UNIT_CMP: case (fun[1:0])
        2'd0: return 8'(a < b);
        2'd1: return 8'(a == b);
        2'd2: return 8'(a > b);
        default: return 8'd0;
      endcase
      default: case (fun[1:0])
        2'd0: return ea << b[1:0];
        2'd1: return ea >> b[1:0];
        2'd2: return {a, b};
        default: return eb;
      endcase
    endcase
  endfunction

  // ALU responder: answers resp_delay cycles after alu_en (0 = never); alu_res is noise otherwise
  initial begin : responder
    int cd;
    logic [3:0] ca, cb, cf;
    cd = 0;
    ca = '0; cb = '0; cf = '0;
    alu_res_valid = 1'b0;
    alu_res       = 8'd0;
    forever begin
      @(negedge CLK);
      alu_res_valid = 1'b0;
      alu_res       = 8'($urandom);
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          alu_res_valid = 1'b1;
          alu_res       = resp_ovr ? resp_val : alu_ref(ca, cb, cf);
        end
      end
      if (alu_en === 1'b1) begin
        cd = resp_delay;
        ca = alu_a;
        cb = alu_b;
        cf = alu_fun;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One command from an idle DUT through to the downstream handshake
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] fun,
                        input int delay, input bit ovr, input logic [7:0] ovr_val, input int hold,
                        input logic [7:0] exp_res, input bit exp_err, input int exp_lat);
    int lat;
    int viol;
    int extra_en;
    int hold_bad;
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    resp_delay = delay;
    resp_ovr   = ovr;
    resp_val   = ovr_val;
    cmd_a      = a;
    cmd_b      = b;
    cmd_fun    = fun;
    cmd_valid  = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    check("issue_alu_en", 32'(alu_en), 32'd1);
    check("issue_operands", 32'({alu_a, alu_b, alu_fun}), 32'({a, b, fun}));
    check("issue_cmd_ready", 32'(cmd_ready), 32'd0);
    lat = 1;
    viol = 0;
    extra_en = 0;
    while (!res_valid && lat < 40) begin
      @(negedge CLK);
      lat++;
      if (cmd_ready || !busy) viol++;
      if (alu_en) extra_en++;
      if ({alu_a, alu_b, alu_fun} != {a, b, fun}) viol++;
    end
    check("accept_to_result_latency", 32'(lat), 32'(exp_lat));
    check("res_data", 32'(res_data), 32'(exp_res));
    check("res_err", 32'(res_err), 32'(exp_err));
    check("single_alu_en_pulse", 32'(extra_en), 32'd0);
    check("inflight_ctl", 32'(viol), 32'd0);
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_a     = ~a;
      @(negedge CLK);
      if (!res_valid || res_data != exp_res || res_err != exp_err || cmd_ready || alu_en) hold_bad++;
    end
    cmd_valid = 1'b0;
    if (hold > 0) check("done_hold_stable", 32'(hold_bad), 32'd0);
    res_ready = 1'b1;
    @(negedge CLK);
    res_ready = 1'b0;
    check("post_handshake_valid_ready_busy", 32'({res_valid, cmd_ready, busy}), 32'(3'b010));
    exp_ops++;
    if (exp_err && exp_to < 255) exp_to++;
  endtask

  // Expected outcome from the timing rule: a reply d cycles after alu_en is taken if d <= TIMEOUT+1
  task automatic run_model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] fun,
                           input int d, input int hold);
    bit ok;
    ok = (d >= 1) && (d <= T + 1);
    run_op(a, b, fun, d, 1'b0, 8'd0, hold, ok ? alu_ref(a, b, fun) : 8'd0, !ok, ok ? d + 2 : T + 3);
  endtask

  initial begin : main
    int bad;
    int w;
    vecs[0] = '{4'd5, 4'd5, 4'b1001, 1, 1'b0, 8'h00, 0, 8'd1,  1'b0, 3};
    vecs[1] = '{4'd9, 4'd2, 4'b0000, 0, 1'b0, 8'h00, 0, 8'd0,  1'b1, 10};
    vecs[2] = '{4'd1, 4'd1, 4'b0000, 8, 1'b1, 8'h2A, 0, 8'h2A, 1'b0, 10};
    vecs[3] = '{4'd2, 4'd3, 4'b0001, 9, 1'b1, 8'h55, 0, 8'h00, 1'b1, 10};
    vecs[4] = '{4'd3, 4'd4, 4'b0000, 2, 1'b0, 8'h00, 5, 8'd7,  1'b0, 4};
    vecs[5] = '{4'hF, 4'hF, 4'b0010, 1, 1'b0, 8'h00, 0, 8'hE1, 1'b0, 3};
    vecs[6] = '{4'hC, 4'hA, 4'b0100, 3, 1'b0, 8'h00, 1, 8'h08, 1'b0, 5};
    vecs[7] = '{4'd3, 4'd2, 4'b1100, 4, 1'b0, 8'h00, 0, 8'h0C, 1'b0, 6};

    RST = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_fun = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_alu_en", 32'(alu_en), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data_err", 32'({res_data, res_err}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_operands", 32'({alu_a, alu_b, alu_fun}), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].delay, vecs[i].ovr, vecs[i].ovr_val,
             vecs[i].hold, vecs[i].exp_res, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // Back-to-back with res_ready held high: one issue every 4 cycles
    en_cyc.delete();
    resp_delay = 1;
    resp_ovr   = 1'b0;
    res_ready  = 1'b1;
    cmd_a = 4'd6; cmd_b = 4'd2; cmd_fun = 4'b0001;
    cmd_valid = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (alu_en) en_cyc.push_back(c);
    end
    cmd_valid = 1'b0;
    check("b2b_issue_count", 32'(en_cyc.size()), 32'd5);
    bad = 0;
    for (int i = 1; i < en_cyc.size(); i++) begin
      if (en_cyc[i] - en_cyc[i-1] != 4) bad++;
    end
    check("b2b_spacing", 32'(bad), 32'd0);
    w = 0;
    while (busy && w < 10) begin
      @(negedge CLK);
      w++;
    end
    check("b2b_drain_idle", 32'(busy), 32'd0);
    res_ready = 1'b0;
    @(negedge CLK);

    // Reset in WAIT, late ALU reply in the cycle after reset must be ignored
    resp_delay = 3;
    resp_ovr   = 1'b0;
    cmd_a = 4'd7; cmd_b = 4'd1; cmd_fun = 4'b0000;
    cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    exp_ops = 0;
    exp_to  = 0;
    check("midrst_outputs", 32'({cmd_ready, alu_en, res_valid, res_err, busy}), 32'(5'b10000));
    check("midrst_data_ops", 32'({res_data, alu_a, alu_b, alu_fun}), 32'd0);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (res_valid || busy || !cmd_ready || alu_en) bad++;
    end
    check("midrst_no_late_result", 32'(bad), 32'd0);

    // Three normal operations plus one timeout
    run_model(4'd2, 4'd3, 4'b0000, 1, 0);
    run_model(4'd9, 4'd4, 4'b0101, 2, 0);
    run_model(4'd8, 4'd8, 4'b1001, 5, 0);
    run_model(4'd1, 4'd6, 4'b0010, 0, 0);
`ifdef ALU_ISSUER_STATS_EN
    check("op_count_after_4", 32'(op_count), 32'd4);
    check("timeout_count_after_4", 32'(timeout_count), 32'd1);
`endif

    for (int i = 0; i < 30; i++) begin
      run_model(4'($urandom), 4'($urandom), 4'($urandom),
                int'($urandom_range(0, 10)), int'($urandom_range(0, 2)));
    end
`ifdef ALU_ISSUER_STATS_EN
    check("op_count_final", 32'(op_count), 32'(exp_ops));
    check("timeout_count_final", 32'(timeout_count), 32'(exp_to));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
